// File: rtl/cpu_pkg.sv
// Shared CPU constants: load-size encodings and default pipeline widths.
package cpu_pkg;

    localparam int DW_DEFAULT       = 32;
    localparam int AW_DEFAULT       = 5;
    localparam int LINK_REG_DEFAULT = 31;

    typedef enum logic [1:0] {
        LD_WORD = 2'b00,
        LD_HALF = 2'b01,
        LD_BYTE = 2'b10,
        LD_RSVD = 2'b11
    } ld_size_e;

endpackage

// File: rtl/load_align.sv
// Little-endian sub-word load alignment with sign/zero extension.
module load_align
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0] word_in,
    input  logic [1:0]    size_in,
    input  logic          unsigned_in,
    input  logic [1:0]    offset_in,
    output logic [DW-1:0] data_out
);

    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    always_comb begin
        half_lane = offset_in[1] ? word_in[31:16] : word_in[15:0];
        byte_lane = word_in[8*offset_in +: 8];
        data_out  = word_in;
        case (ld_size_e'(size_in))
            LD_HALF: data_out = unsigned_in ? {{(DW-16){1'b0}}, half_lane}
                                            : {{(DW-16){half_lane[15]}}, half_lane};
            LD_BYTE: data_out = unsigned_in ? {{(DW-8){1'b0}}, byte_lane}
                                            : {{(DW-8){byte_lane[7]}}, byte_lane};
            default: data_out = word_in;
        endcase
    end

endmodule

// File: rtl/write_back_pipe.sv
// Registered write-back stage: captures MEM results, selects the write-back
// source, steers the destination register and counts retired instructions.
module write_back_pipe
    import cpu_pkg::*;
#(
    parameter int DW                 = DW_DEFAULT,
    parameter int AW                 = AW_DEFAULT,
    parameter int LINK_REG           = LINK_REG_DEFAULT,
    parameter int LINK_OFFSET        = 0,
    parameter int ZERO_REG_HARDWIRED = 1,
    parameter int CW                 = 32
) (
    input  logic          clock,
    input  logic          aclr,
    input  logic          stall_in,
    input  logic          flush_in,
    input  logic          valid_in,
    input  logic [DW-1:0] pc_in,
    input  logic [DW-1:0] alu_in,
    input  logic [DW-1:0] mem_in,
    input  logic [AW-1:0] rd_in,
    input  logic          reg_wr_in,
    input  logic          m2reg_in,
    input  logic          jal_in,
    input  logic [1:0]    ld_size_in,
    input  logic          ld_unsigned_in,
    input  logic [1:0]    byte_off_in,
    output logic [DW-1:0] data_wb,
    output logic [AW-1:0] rd_wb,
    output logic          reg_wb,
    output logic          valid_wb,
    output logic [CW-1:0] retire_count
);

    localparam logic [AW-1:0] LINK_RD  = AW'(LINK_REG);
    localparam logic [DW-1:0] LINK_ADD = DW'(LINK_OFFSET);
    localparam logic          ZERO_HW  = (ZERO_REG_HARDWIRED != 0);

    logic          valid_q, valid_d;
    logic [DW-1:0] pc_q, pc_d, alu_q, alu_d, mem_q, mem_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          reg_wr_q, reg_wr_d, m2reg_q, m2reg_d, jal_q, jal_d;
    logic [1:0]    ld_size_q, ld_size_d, byte_off_q, byte_off_d;
    logic          unsigned_q, unsigned_d;
    logic [CW-1:0] retire_q, retire_d;
    logic [DW-1:0] load_data;

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        alu_d      = alu_q;
        mem_d      = mem_q;
        rd_d       = rd_q;
        reg_wr_d   = reg_wr_q;
        m2reg_d    = m2reg_q;
        jal_d      = jal_q;
        ld_size_d  = ld_size_q;
        unsigned_d = unsigned_q;
        byte_off_d = byte_off_q;
        retire_d   = retire_q;
        // The resident instruction leaves on any flush or unstalled edge.
        if (valid_q && (flush_in || !stall_in)) begin
            retire_d = retire_q + 1'b1;
        end
        if (flush_in) begin
            valid_d = 1'b0;
        end else if (!stall_in) begin
            valid_d    = valid_in;
            pc_d       = pc_in;
            alu_d      = alu_in;
            mem_d      = mem_in;
            rd_d       = rd_in;
            reg_wr_d   = reg_wr_in;
            m2reg_d    = m2reg_in;
            jal_d      = jal_in;
            ld_size_d  = ld_size_in;
            unsigned_d = ld_unsigned_in;
            byte_off_d = byte_off_in;
        end
    end

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            alu_q      <= '0;
            mem_q      <= '0;
            rd_q       <= '0;
            reg_wr_q   <= 1'b0;
            m2reg_q    <= 1'b0;
            jal_q      <= 1'b0;
            ld_size_q  <= 2'b00;
            unsigned_q <= 1'b0;
            byte_off_q <= 2'b00;
            retire_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            alu_q      <= alu_d;
            mem_q      <= mem_d;
            rd_q       <= rd_d;
            reg_wr_q   <= reg_wr_d;
            m2reg_q    <= m2reg_d;
            jal_q      <= jal_d;
            ld_size_q  <= ld_size_d;
            unsigned_q <= unsigned_d;
            byte_off_q <= byte_off_d;
            retire_q   <= retire_d;
        end
    end

    load_align #(.DW(DW)) u_load_align (
        .word_in     (mem_q),
        .size_in     (ld_size_q),
        .unsigned_in (unsigned_q),
        .offset_in   (byte_off_q),
        .data_out    (load_data)
    );

    always_comb begin
        if (jal_q) begin
            data_wb = pc_q + LINK_ADD;
            rd_wb   = LINK_RD;
        end else if (m2reg_q) begin
            data_wb = load_data;
            rd_wb   = rd_q;
        end else begin
            data_wb = alu_q;
            rd_wb   = rd_q;
        end
        reg_wb = valid_q && (reg_wr_q || jal_q) && !(ZERO_HW && (rd_wb == '0));
    end

    assign valid_wb     = valid_q;
    assign retire_count = retire_q;

endmodule

// File: doc/write_back_pipe.md
Name: write_back_pipe

Overview:
- Parametrised, registered write-back stage for the pipelined CPU; sits between the MEM stage and the register file.
- Captures MEM-stage results in its own pipeline register, with stall, flush and valid tracking.
- Selects the write-back source: ALU result, aligned and extended sub-word load data, or the link address for jal.
- Steers the destination register, suppresses writes to the hard-wired zero register, and counts retired instructions.

Parameters:
- DW, 32, data/PC width; multiple of 8, minimum 32.
- AW, 5, register-address width.
- LINK_REG, 31, destination index for jal.
- LINK_OFFSET, 0, constant added to the captured PC to form the link value.
- ZERO_REG_HARDWIRED, 1, when 1 any write to register 0 is suppressed.
- CW, 32, retire-counter width.

Ports:
- clock  in  1  rising-edge clock
- aclr  in  1  asynchronous reset, active-low
- stall_in  in  1  hold the stage register
- flush_in  in  1  load a bubble; overrides stall_in
- valid_in  in  1  MEM-stage slot holds a real instruction
- pc_in  in  DW  PC associated with the instruction
- alu_in  in  DW  ALU result
- mem_in  in  DW  raw memory read word
- rd_in  in  AW  destination register
- reg_wr_in  in  1  instruction writes the register file
- m2reg_in  in  1  select memory data
- jal_in  in  1  jump-and-link
- ld_size_in  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- ld_unsigned_in  in  1  zero-extend sub-word loads
- byte_off_in  in  2  address bits [1:0] of the load
- data_wb  out  DW  register-file write data
- rd_wb  out  AW  register-file write address
- reg_wb  out  1  register-file write enable
- valid_wb  out  1  stage holds a valid instruction
- retire_count  out  CW  retired-instruction count

Behaviour:
- Reset (aclr=0, asynchronous): all stage registers and retire_count clear to 0. Outputs during and after reset until the first capture: data_wb=0, rd_wb=0, reg_wb=0, valid_wb=0, retire_count=0.
- Stage register, at each rising edge:
  - flush_in=1: valid_q<=0; other captured fields are don't-care.
  - else stall_in=0: capture all *_in fields.
  - else (stall_in=1): hold all fields.
- Latency: inputs appear on the outputs one cycle after capture. data_wb, rd_wb and reg_wb are combinational from the registered fields only, with no input-to-output path.
- Source priority:
  - jal_q=1: data_wb = pc_q + LINK_OFFSET (modulo 2^DW), rd_wb = LINK_REG.
  - else m2reg_q=1: data_wb = aligned load data, rd_wb = rd_q.
  - else: data_wb = alu_q, rd_wb = rd_q.
- Load alignment (little-endian, low 32 bits of mem_q):
  - half: lane = byte_off_q[1] ? [31:16] : [15:0]; byte_off_q[0] is ignored.
  - byte: lane = byte byte_off_q.
  - Sign-extend to DW unless unsigned_q=1, then zero-extend.
  - word: mem_q unchanged.
- Write enable: reg_wb = valid_q & (reg_wr_q | jal_q) & !(ZERO_REG_HARDWIRED & rd_wb==0).
  - jal forces a write regardless of reg_wr_q.
- Stalled instruction: held outputs and reg_wb stay asserted every stalled cycle; repeated writes are idempotent by design.
- Retire counter: increments by 1 at the edge where valid_q=1 and (stall_in=0 or flush_in=1), i.e. the resident instruction departs. Wraps 2^CW-1 -> 0.
  - Flush kills only the incoming instruction; the resident one retires.
- Simultaneous flush_in and stall_in: flush wins.
- aclr asserted mid-stall: state clears immediately; stall has no effect while aclr=0.

Decomposition:
- Shared package cpu_pkg:
  - ld_size encodings LD_WORD / LD_HALF / LD_BYTE.
  - Default LINK_REG value.
  - Default DW / AW constants.
- One combinational sub-module load_align (inputs: word, size, unsigned, offset; output: DW value). Reused later by the forwarding unit.

Test Plan:
- Reset: aclr=0 with random inputs -> all outputs 0; release, valid_in=1, alu_in=32'h1234, rd_in=5, reg_wr_in=1 -> next cycle data_wb=32'h1234, rd_wb=5, reg_wb=1, valid_wb=1.
- Loads: mem_in=32'h80FF7F01:
  - byte off=3 signed -> 32'hFFFFFF80
  - byte off=1 unsigned -> 32'h0000007F
  - half off=2 signed -> 32'hFFFF80FF
  - half off=0 unsigned -> 32'h00007F01
  - word -> 32'h80FF7F01
- jal: pc_in=32'h40, LINK_OFFSET=4, reg_wr_in=0, rd_in=7 -> rd_wb=31, data_wb=32'h44, reg_wb=1.
- Zero register: rd_in=0, reg_wr_in=1 -> reg_wb=0. Same with ZERO_REG_HARDWIRED=0 -> reg_wb=1.
- Stall/flush:
  - 3 valid instructions with stall_in=1 for 2 cycles on the second -> outputs held 2 extra cycles, retire_count=3 after drain.
  - flush_in together with stall_in -> valid_wb=0 next cycle, and the resident instruction is counted.
- Counter wrap: CW=4, 17 retirements -> retire_count=1.
